multi_channel_pulse_detector: RTL and testbench
===============================================

Name: multi_channel_pulse_detector

Overview:
- N-channel edge and pulse-width detector for asynchronous-free, already-synchronised single-bit inputs.
- Each channel has a runtime mode: rising edge, falling edge, any edge, or pulse of width within [min_len, max_len].
- Each channel has polarity control and a registered measured-length report.
- Sits between input synchronisers and event/interrupt logic. Generalises the single-channel posedge and one-cycle (010) pulse detectors.

Parameters:
- N, 4, number of independent channels (>=1)
- CNT_W, 8, width of per-channel run-length counter; MAX_CNT = 2**CNT_W - 1

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  synchronous reset, active-high
- a  input  N  per-channel input samples
- pol  input  N  per-channel polarity; 1 = active-low (input inverted before detection)
- mode  input  N x 2  per-channel mode (packed [N-1:0][1:0]); see package enum
- min_len  input  CNT_W  minimum accepted pulse width, shared by all channels
- max_len  input  CNT_W  maximum accepted pulse width, shared by all channels
- detected  output  N  per-channel detection, combinational (Mealy) from current a
- len_valid  output  N  registered one-cycle strobe: a pulse just ended
- len  output  N x CNT_W  registered width of last ended pulse, held until next end

Behaviour:
- Effective input per channel: e = a ^ pol. State per channel: prev (e of last cycle), cnt (consecutive active cycles up to last cycle), len, len_valid.
- Reset: prev=0, cnt=0, len=0, len_valid=0. detected is then a pure function of e: if e=1 in the first cycle after reset, that is a rising edge (same as single-channel posedge detector).
- Counter, per cycle:
  - e=1: cnt <= sat(cnt+1), saturating at MAX_CNT, no wrap.
  - e=0 and prev=1 (pulse end): cnt <= 0; len <= cnt; len_valid <= 1.
  - Otherwise: len_valid <= 0, cnt <= 0.
- Detection, combinational, same cycle as the qualifying sample:
  - RISE (2'b00): ~prev & e
  - FALL (2'b01): prev & ~e
  - ANY (2'b10): prev ^ e
  - PULSE (2'b11): prev & ~e & (cnt >= min_len) & (cnt <= max_len)
  - Example: PULSE mode with min=max=1 reproduces 010 detection exactly, asserted on the cycle the 0 follows the single 1.
- Latency: detected 0 cycles after the qualifying sample. len/len_valid 1 cycle after the pulse-end sample.
- Boundaries:
  - min_len=0 behaves as 1 (cnt>=1 at any end).
  - min_len>max_len: PULSE never fires.
  - A saturated pulse reports len=MAX_CNT and qualifies only if max_len==MAX_CNT.
  - A pulse still active never reports; no timeout.
  - Counters run in all modes.
  - mode/min/max/pol changes take effect combinationally in the same cycle; no shadowing.
  - A pol toggle may itself create an edge; accepted.
- Reset mid-pulse: pulse discarded, no len_valid. If input is still active after reset, it counts as a new rise with cnt starting at 1 on the next cycle.
- Channels are fully independent; simultaneous events on any subset are reported in parallel.

Decomposition:
- Package pulse_det_pkg: typedef enum logic [1:0] {MODE_RISE, MODE_FALL, MODE_ANY, MODE_PULSE} det_mode_e. Also a sat_inc function parametrised via CNT_W argument width.
- Sub-module pulse_det_chan: one channel (prev, cnt, len, len_valid, detect mux), parameter CNT_W. Top instantiates N copies in a generate loop and fans out shared min_len/max_len.

Test Plan:
- Reset with a[0]=1 held, RISE mode -> detected[0]=1 in first post-reset cycle, 0 thereafter; len_valid stays 0 until a[0] drops.
- Channel 1 PULSE, min=max=1, stimulus 0,1,0 -> detected[1]=1 only on the third cycle. Stimulus 0,1,1,0 -> no detect, len_valid next cycle with len=2.
- Channel 2 PULSE, min=3 max=5, pulses of width 2,3,5,6 -> detect only for widths 3 and 5; len sequence 2,3,5,6.
- CNT_W=4, pulse width 20 -> len=15. Detect with max_len=15; no detect with max_len=14.
- pol[3]=1, ANY mode, a[3]=1,1,0,0,1 -> detected[3]=1 on cycles 3 and 5; len=2 reported after cycle 5.
- All four channels in different modes with simultaneous edges -> each detected bit matches its own mode. Reset asserted mid-pulse -> no len_valid for the aborted pulse.

Source files
------------

// File: rtl/pulse_det_pkg.sv
// Purpose: shared types and helpers for the multi-channel pulse detector.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: det_mode_e (per-channel detection mode encoding), sat_inc (saturating increment).
package pulse_det_pkg;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_ANY   = 2'b10,
    MODE_PULSE = 2'b11
  } det_mode_e;

  // Widest counter sat_inc can serve; callers pass their real width in w.
  localparam int unsigned SAT_MAX_W = 32;

  // Increment v, holding at 2**w - 1 instead of wrapping.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [SAT_MAX_W-1:0] one;
    logic [SAT_MAX_W-1:0] lim;
    one = SAT_MAX_W'(1);
    lim = (w >= SAT_MAX_W) ? '1 : ((one << w) - one);
    return (v >= lim) ? lim : (v + one);
  endfunction

endpackage

// File: rtl/pulse_det_chan.sv
// Purpose: one detector channel: polarity, edge/pulse detect, run-length counter, length report.
// Latency: detected is combinational from a; len/len_valid 1 cycle after the pulse-end sample.
// Backpressure: none; every sample is consumed, len_valid is a one-cycle strobe.
// Ports: clk, rst (sync, active-high); a, pol (sample and its polarity); mode (det_mode_e);
//        min_len/max_len (accepted PULSE width window); detected, len_valid, len (outputs).
module pulse_det_chan
  import pulse_det_pkg::*;
#(
  parameter int CNT_W = 8  // must not exceed SAT_MAX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             pol,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] min_len,
  input  logic [CNT_W-1:0] max_len,
  output logic             detected,
  output logic             len_valid,
  output logic [CNT_W-1:0] len
);

  logic             e;
  logic             prev;
  logic             pulse_end;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign e         = a ^ pol;
  assign pulse_end = prev & ~e;
  assign cnt_inc   = CNT_W'(sat_inc(SAT_MAX_W'(cnt), CNT_W));

  // cnt holds the run length up to the previous sample, so at a pulse end it
  // is exactly the width of the pulse that just finished (always >= 1, which
  // is why min_len = 0 acts like 1).
  always_comb begin
    detected = 1'b0;
    case (det_mode_e'(mode))
      MODE_RISE:  detected = ~prev & e;
      MODE_FALL:  detected = pulse_end;
      MODE_ANY:   detected = prev ^ e;
      MODE_PULSE: detected = pulse_end & (cnt >= min_len) & (cnt <= max_len);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= 1'b0;
      cnt       <= '0;
      len       <= '0;
      len_valid <= 1'b0;
    end else begin
      prev <= e;
      if (e) begin
        cnt       <= cnt_inc;
        len_valid <= 1'b0;
      end else if (prev) begin
        cnt       <= '0;
        len       <= cnt;
        len_valid <= 1'b1;
      end else begin
        cnt       <= '0;
        len_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_channel_pulse_detector.sv
// Purpose: N independent edge / pulse-width detectors with per-channel mode and polarity.
// Latency: detected same cycle as the qualifying sample; len/len_valid one cycle after pulse end.
// Backpressure: none; inputs sampled every cycle, outputs are strobes/held values.
// Ports: clk, rst (sync, active-high); a[N], pol[N], mode[N][2]; min_len/max_len shared window;
//        detected[N] (combinational), len_valid[N] (strobe), len[N][CNT_W] (held).
module multi_channel_pulse_detector
  import pulse_det_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              a,
  input  logic [N-1:0]              pol,
  input  logic [N-1:0][1:0]         mode,
  input  logic [CNT_W-1:0]          min_len,
  input  logic [CNT_W-1:0]          max_len,
  output logic [N-1:0]              detected,
  output logic [N-1:0]              len_valid,
  output logic [N-1:0][CNT_W-1:0]   len
);

  for (genvar g = 0; g < N; g++) begin : g_chan
    pulse_det_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .a        (a[g]),
      .pol      (pol[g]),
      .mode     (mode[g]),
      .min_len  (min_len),
      .max_len  (max_len),
      .detected (detected[g]),
      .len_valid(len_valid[g]),
      .len      (len[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_pulse_detector.sv
module tb_multi_channel_pulse_detector;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int MAXC = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        a;
  logic [N-1:0]        pol;
  logic [N-1:0][1:0]   mode;
  logic [W-1:0]        min_len;
  logic [W-1:0]        max_len;
  logic [N-1:0]        detected;
  logic [N-1:0]        len_valid;
  logic [N-1:0][W-1:0] len;

  always #5 clk = ~clk;

  multi_channel_pulse_detector #(.N(N), .CNT_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .pol      (pol),
    .mode     (mode),
    .min_len  (min_len),
    .max_len  (max_len),
    .detected (detected),
    .len_valid(len_valid),
    .len      (len)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  a;
    logic [3:0]  pol;
    logic [7:0]  mode;
    logic [3:0]  mn;
    logic [3:0]  mx;
    logic [3:0]  det;
    logic [3:0]  lv;
    logic [15:0] ln;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: raw history of effective samples since the last reset
  // (bit 0 = most recent), plus the registered length report.
  logic [63:0] hist[N];
  int          hlen[N];
  logic [3:0]  m_lv;
  logic [15:0] m_len;
  bit          model_ok = 1'b0;

  function automatic int run_of(int ch);
    int r = 0;
    for (int k = 0; k < hlen[ch]; k++) begin
      if (hist[ch][k]) r++;
      else break;
    end
    return (r > MAXC) ? MAXC : r;
  endfunction

  function automatic logic prev_of(int ch);
    return (hlen[ch] > 0) ? hist[ch][0] : 1'b0;
  endfunction

  function automatic logic model_det(logic [1:0] m, logic p, logic e, int run, int mn, int mx);
    case (m)
      2'b00:   return !p && e;
      2'b01:   return p && !e;
      2'b10:   return p != e;
      default: return p && !e && (run >= mn) && (run <= mx);
    endcase
  endfunction

  task automatic check(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at step %0d: got %h, expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] av, input logic [3:0] mn, input logic [3:0] mx,
                     input logic [3:0] det, input logic [3:0] lv, input logic [15:0] ln);
    vec_t v;
    v.rst = r; v.a = av; v.pol = 4'b1000; v.mode = 8'hBC;
    v.mn = mn; v.mx = mx; v.det = det; v.lv = lv; v.ln = ln;
    tbl.push_back(v);
  endtask

  task automatic addn(input int n, input logic [3:0] av, input logic [3:0] mn, input logic [3:0] mx,
                      input logic [15:0] ln);
    for (int i = 0; i < n; i++) add(1'b0, av, mn, mx, 4'b0000, 4'b0000, ln);
  endtask

  // One clock: compare at the falling edge, then advance the model.
  task automatic cycle(input bit have_exp, input vec_t v, input int idx);
    logic [3:0]  mdet;
    logic        e;
    int          r;
    @(negedge clk);
    if (have_exp) begin
      check("tbl_detected",  idx, {12'b0, detected},  {12'b0, v.det});
      check("tbl_len_valid", idx, {12'b0, len_valid}, {12'b0, v.lv});
      check("tbl_len",       idx, len,                v.ln);
    end
    if (model_ok) begin
      for (int ch = 0; ch < N; ch++) begin
        e = a[ch] ^ pol[ch];
        mdet[ch] = model_det(mode[ch], prev_of(ch), e, run_of(ch), int'(min_len), int'(max_len));
      end
      check("model_detected",  idx, {12'b0, detected},  {12'b0, mdet});
      check("model_len_valid", idx, {12'b0, len_valid}, {12'b0, m_lv});
      check("model_len",       idx, len,                m_len);
    end
    if (rst) begin
      for (int ch = 0; ch < N; ch++) begin
        hist[ch] = '0;
        hlen[ch] = 0;
      end
      m_lv     = '0;
      m_len    = '0;
      model_ok = 1'b1;
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        e = a[ch] ^ pol[ch];
        r = run_of(ch);
        if (!e && prev_of(ch)) begin
          m_lv[ch] = 1'b1;
          m_len[ch*4 +: 4] = 4'(r);
        end else begin
          m_lv[ch] = 1'b0;
        end
        hist[ch] = {hist[ch][62:0], e};
        if (hlen[ch] < 64) hlen[ch]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       v;
    vec_t       none;
    int         widths[4];
    logic [15:0] lcur;
    int         hold[N];

    // Directed table: ch0 RISE, ch1 PULSE, ch2 PULSE, ch3 ANY (active-low).
    add(1'b0, 4'b1001, 4'd1, 4'd1, 4'b0001, 4'b0000, 16'h0000);
    addn(2, 4'b1001, 4'd1, 4'd1, 16'h0000);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h0000);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0001, 16'h0003);
    // ch1 single-cycle pulse 0,1,0 then 0,1,1,0 with min=max=1
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h0003);
    add(1'b0, 4'b1010, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h0003);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0010, 4'b0000, 16'h0003);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0010, 16'h0013);
    addn(2, 4'b1010, 4'd1, 4'd1, 16'h0013);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h0013);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0010, 16'h0023);
    // ch2 window [3,5], widths 2,3,5,6
    widths = '{2, 3, 5, 6};
    lcur   = 16'h0023;
    for (int i = 0; i < 4; i++) begin
      addn(widths[i], 4'b1100, 4'd3, 4'd5, lcur);
      add(1'b0, 4'b1000, 4'd3, 4'd5,
          (widths[i] >= 3 && widths[i] <= 5) ? 4'b0100 : 4'b0000, 4'b0000, lcur);
      lcur = {lcur[15:12], 4'(widths[i]), lcur[7:0]};
      add(1'b0, 4'b1000, 4'd3, 4'd5, 4'b0000, 4'b0100, lcur);
    end
    // ch3 active-low ANY: a3 = 1,1,0,0,1
    addn(2, 4'b1000, 4'd3, 4'd5, 16'h0623);
    add(1'b0, 4'b0000, 4'd3, 4'd5, 4'b1000, 4'b0000, 16'h0623);
    add(1'b0, 4'b0000, 4'd3, 4'd5, 4'b0000, 4'b0000, 16'h0623);
    add(1'b0, 4'b1000, 4'd3, 4'd5, 4'b1000, 4'b0000, 16'h0623);
    add(1'b0, 4'b1000, 4'd3, 4'd5, 4'b0000, 4'b1000, 16'h2623);
    // ch2 width 20 saturates at 15: qualifies with max=15, not with max=14
    addn(20, 4'b1100, 4'd3, 4'd15, 16'h2623);
    add(1'b0, 4'b1000, 4'd3, 4'd15, 4'b0100, 4'b0000, 16'h2623);
    add(1'b0, 4'b1000, 4'd3, 4'd15, 4'b0000, 4'b0100, 16'h2F23);
    addn(20, 4'b1100, 4'd3, 4'd14, 16'h2F23);
    add(1'b0, 4'b1000, 4'd3, 4'd14, 4'b0000, 4'b0000, 16'h2F23);
    add(1'b0, 4'b1000, 4'd3, 4'd14, 4'b0000, 4'b0100, 16'h2F23);
    // simultaneous events on all channels
    add(1'b0, 4'b1010, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h2F23);
    add(1'b0, 4'b0101, 4'd1, 4'd1, 4'b1011, 4'b0000, 16'h2F23);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b1100, 4'b0010, 16'h2F13);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b1101, 16'h1111);
    // reset mid-pulse: aborted pulse never reports
    add(1'b0, 4'b1100, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h1111);
    add(1'b0, 4'b1100, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h1111);
    add(1'b1, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h1111);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h0000);
    // input held active through reset restarts counting at 1
    add(1'b0, 4'b1100, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h0000);
    add(1'b1, 4'b1100, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h0000);
    add(1'b0, 4'b1100, 4'd1, 4'd1, 4'b0000, 4'b0000, 16'h0000);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0100, 4'b0000, 16'h0000);
    add(1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 4'b0100, 16'h0100);

    // Reset with a[0] held high.
    rst = 1'b1; a = 4'b1001; pol = 4'b1000; mode = 8'hBC; min_len = 4'd1; max_len = 4'd1;
    cycle(1'b0, none, -2);
    cycle(1'b0, none, -1);

    foreach (tbl[i]) begin
      v       = tbl[i];
      rst     = v.rst;
      a       = v.a;
      pol     = v.pol;
      mode    = v.mode;
      min_len = v.mn;
      max_len = v.mx;
      cycle(1'b1, v, i);
    end

    // Randomised phase against the model.
    for (int ch = 0; ch < N; ch++) hold[ch] = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0)
        for (int ch = 0; ch < N; ch++) begin
          case ($urandom_range(0, 3))
            0: hold[ch] = 1;
            1: hold[ch] = 3;
            2: hold[ch] = 8;
            default: hold[ch] = 25;
          endcase
        end
      if (cyc % 50 == 0) begin
        mode    = 8'($urandom);
        min_len = 4'($urandom_range(0, 6));
        max_len = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 8));
      end
      rst = ($urandom_range(0, 59) == 0);
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, hold[ch]) == 0) a[ch] = ~a[ch];
        if ($urandom_range(0, 31) == 0) pol[ch] = ~pol[ch];
      end
      cycle(1'b0, none, 1000 + cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
